// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: FSM states,
// access-size encodings and the byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatting: shifts the addressed lane down to bit 0, then
// truncates to the access size and sign- or zero-extends to 64 bits.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    value   = shifted;
    unique case (size)
      MEM_B: value = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_H: value = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_W: value = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      MEM_D: value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one instruction in flight, loads/stores go over the
// dmem request/response bus, everything else passes straight to write-back.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [XLEN-1:0]       ex_alu_res,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic                  ex_mem_ld,
  input  logic                  ex_mem_st,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic                  ex_reg_wen,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_req_addr,
  output logic                  dmem_req_wen,
  output logic [XLEN-1:0]       dmem_req_wdata,
  output logic [7:0]            dmem_req_wmask,
  input  logic                  dmem_resp_valid,
  input  logic [XLEN-1:0]       dmem_resp_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_reg_wen,
  output logic [REG_ADDR_W-1:0] wb_reg_waddr,
  output logic [XLEN-1:0]       wb_rdata,
  output logic [XLEN-1:0]       wb_pc,
  output logic                  misalign_err
);

  state_t state, state_next;

  logic                  accept, ex_mem, ex_misaligned, pass_through;
  logic [3:0]            ex_nbytes;
  logic [2:0]            ex_low_mask;

  logic [XLEN-1:0]       pc_p1, addr_p1, sdata_p1;
  logic                  ld_p1, st_p1, uns_p1, wen_p1;
  logic [1:0]            size_p1;
  logic [REG_ADDR_W-1:0] waddr_p1;

  logic [XLEN-1:0]       rdata_p2;
  logic                  wen_p2, mis_p2;

  logic                  req_active, is_store;
  logic [7:0]            base_mask;
  logic [XLEN-1:0]       load_value;

  assign accept        = ex_valid && ex_ready;
  assign ex_mem        = ex_mem_ld || ex_mem_st;
  assign ex_nbytes     = size_bytes(ex_mem_size);
  assign ex_low_mask   = 3'(ex_nbytes - 4'd1);
  assign ex_misaligned = |(ex_alu_res[2:0] & ex_low_mask);
  assign pass_through  = !ex_mem || ex_misaligned;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = pass_through ? OUT : REQ;
      REQ:  if (dmem_req_ready) state_next = RESP;
      RESP: if (dmem_resp_valid) state_next = OUT;
      OUT:  if (wb_ready) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  // p1: instruction captured at acceptance
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_p1    <= '0;
      addr_p1  <= '0;
      sdata_p1 <= '0;
      ld_p1    <= 1'b0;
      st_p1    <= 1'b0;
      size_p1  <= MEM_B;
      uns_p1   <= 1'b0;
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
    end else if (accept) begin
      pc_p1    <= ex_pc;
      addr_p1  <= ex_alu_res;
      sdata_p1 <= ex_store_data;
      ld_p1    <= ex_mem_ld;
      st_p1    <= ex_mem_st;
      size_p1  <= ex_mem_size;
      uns_p1   <= ex_mem_unsigned;
      wen_p1   <= ex_reg_wen;
      waddr_p1 <= ex_reg_waddr;
    end
  end

  // Load wins when both ld and st are flagged.
  assign is_store   = st_p1 && !ld_p1;
  assign req_active = (state == REQ);

  always_comb begin
    base_mask = 8'h01;
    unique case (size_p1)
      MEM_B: base_mask = 8'h01;
      MEM_H: base_mask = 8'h03;
      MEM_W: base_mask = 8'h0F;
      MEM_D: base_mask = 8'hFF;
    endcase
  end

  assign dmem_req_valid = req_active;
  assign dmem_req_addr  = req_active ? {addr_p1[XLEN-1:3], 3'b000} : '0;
  assign dmem_req_wen   = req_active && is_store;
  assign dmem_req_wdata = (req_active && is_store) ? (sdata_p1 << {addr_p1[2:0], 3'b000}) : '0;
  assign dmem_req_wmask = (req_active && is_store) ? (base_mask << addr_p1[2:0]) : 8'h00;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (dmem_resp_rdata),
    .offset      (addr_p1[2:0]),
    .size        (size_p1),
    .is_unsigned (uns_p1),
    .value       (load_value)
  );

  // p2: write-back payload, loaded on entry to OUT and held there
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata_p2 <= '0;
      wen_p2   <= 1'b0;
      mis_p2   <= 1'b0;
    end else begin
      mis_p2 <= accept && ex_mem && ex_misaligned;
      if (accept && pass_through) begin
        rdata_p2 <= ex_mem ? '0 : ex_alu_res;
        wen_p2   <= ex_mem ? 1'b0 : ex_reg_wen;
      end else if (state == RESP && dmem_resp_valid) begin
        rdata_p2 <= ld_p1 ? load_value : '0;
        wen_p2   <= ld_p1 && wen_p1;
      end
    end
  end

  assign ex_ready     = (state == IDLE);
  assign wb_valid     = (state == OUT);
  assign wb_reg_wen   = (state == OUT) && wen_p2;
  assign wb_reg_waddr = waddr_p1;
  assign wb_rdata     = rdata_p2;
  assign wb_pc        = pc_p1;
  assign misalign_err = mis_p2;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single transactions plus
// hand-written sequences for stalls, backpressure and mid-transaction reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_pc, ex_alu_res, ex_store_data;
  logic        ex_mem_ld, ex_mem_st;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned, ex_reg_wen;
  logic [4:0]  ex_reg_waddr;
  logic        dmem_req_valid, dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic        wb_valid, wb_ready, wb_reg_wen;
  logic [4:0]  wb_reg_waddr;
  logic [63:0] wb_rdata, wb_pc;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
    .ex_mem_ld(ex_mem_ld), .ex_mem_st(ex_mem_st), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_reg_wen(ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg_wen(wb_reg_wen),
    .wb_reg_waddr(wb_reg_waddr), .wb_rdata(wb_rdata), .wb_pc(wb_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr, sdata, mem;
    logic        ld, st;
    logic [1:0]  size;
    logic        uns, wen;
    logic [4:0]  rd;
    logic        bus;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wmask;
    logic        exp_req_wen;
    logic [63:0] exp_rdata;
    logic        exp_wen, exp_mis;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] mem,
    input logic ld, input logic st, input logic [1:0] size, input logic uns,
    input logic wen, input logic [4:0] rd, input logic bus,
    input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
    input logic [7:0] exp_wmask, input logic exp_req_wen,
    input logic [63:0] exp_rdata, input logic exp_wen, input logic exp_mis);
    vec_t v;
    v.addr = addr; v.sdata = sdata; v.mem = mem; v.ld = ld; v.st = st;
    v.size = size; v.uns = uns; v.wen = wen; v.rd = rd; v.bus = bus;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
    v.exp_req_wen = exp_req_wen; v.exp_rdata = exp_rdata;
    v.exp_wen = exp_wen; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic [63:0] pc, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic ld, input logic st,
                          input logic [1:0] size, input logic uns,
                          input logic wen, input logic [4:0] rd);
    ex_valid = 1'b1; ex_pc = pc; ex_alu_res = addr; ex_store_data = sdata;
    ex_mem_ld = ld; ex_mem_st = st; ex_mem_size = size; ex_mem_unsigned = uns;
    ex_reg_wen = wen; ex_reg_waddr = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // Entered at posedge+1 with the stage idle and wb_ready high.
  task automatic do_vec(input int i, input vec_t v);
    logic [63:0] pc;
    pc = 64'h1000 + 64'(i * 4);
    drive_ex(pc, v.addr, v.sdata, v.ld, v.st, v.size, v.uns, v.wen, v.rd);
    @(negedge clk);
    chk($sformatf("v%0d req_valid", i), 64'(dmem_req_valid), 64'(v.bus));
    chk($sformatf("v%0d ex_ready_busy", i), 64'(ex_ready), 64'd0);
    if (v.bus) begin
      chk($sformatf("v%0d req_addr", i), dmem_req_addr, v.exp_addr);
      chk($sformatf("v%0d req_wen", i), 64'(dmem_req_wen), 64'(v.exp_req_wen));
      chk($sformatf("v%0d req_wdata", i), dmem_req_wdata, v.exp_wdata);
      chk($sformatf("v%0d req_wmask", i), 64'(dmem_req_wmask), 64'(v.exp_wmask));
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = v.mem;
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
    end
    chk($sformatf("v%0d wb_valid", i), 64'(wb_valid), 64'd1);
    chk($sformatf("v%0d wb_rdata", i), wb_rdata, v.exp_rdata);
    chk($sformatf("v%0d wb_reg_wen", i), 64'(wb_reg_wen), 64'(v.exp_wen));
    chk($sformatf("v%0d wb_reg_waddr", i), 64'(wb_reg_waddr), 64'(v.rd));
    chk($sformatf("v%0d wb_pc", i), wb_pc, pc);
    chk($sformatf("v%0d misalign_err", i), 64'(misalign_err), 64'(v.exp_mis));
    @(posedge clk); #1;
  endtask

  initial begin
    //            addr                   sdata                  mem                    ld st sz u wen rd bus exp_addr               exp_wdata              wmask rw exp_rdata              wen mis
    vecs[0]  = mk(64'h1234,              64'h0,                 64'h0,                 0, 0, 3, 0, 1, 5, 0, 64'h0,                64'h0,                 8'h00, 0, 64'h1234,              1, 0);
    vecs[1]  = mk(64'h8000_0003,         64'h0,                 64'h0000_0000_8000_0000, 1, 0, 0, 0, 1, 7, 1, 64'h8000_0000,     64'h0,                 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
    vecs[2]  = mk(64'h8000_0003,         64'h0,                 64'h0000_0000_8000_0000, 1, 0, 0, 1, 1, 7, 1, 64'h8000_0000,     64'h0,                 8'h00, 0, 64'h80,                1, 0);
    vecs[3]  = mk(64'h8000_0004,         64'hDEAD_BEEF,         64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 2, 0, 1, 3, 1, 64'h8000_0000,     64'hDEAD_BEEF_0000_0000, 8'hF0, 1, 64'h0,                0, 0);
    vecs[4]  = mk(64'h8000_0001,         64'h0,                 64'h0,                 1, 0, 1, 0, 1, 4, 0, 64'h0,                64'h0,                 8'h00, 0, 64'h0,                 0, 1);
    vecs[5]  = mk(64'h10,                64'h0,                 64'h0123_4567_89AB_CDEF, 1, 0, 3, 0, 1, 8, 1, 64'h10,            64'h0,                 8'h00, 0, 64'h0123_4567_89AB_CDEF, 1, 0);
    vecs[6]  = mk(64'h24,                64'h0,                 64'h8765_4321_0000_0000, 1, 0, 2, 0, 1, 9, 1, 64'h20,            64'h0,                 8'h00, 0, 64'hFFFF_FFFF_8765_4321, 1, 0);
    vecs[7]  = mk(64'h24,                64'h0,                 64'h8765_4321_0000_0000, 1, 0, 2, 1, 1, 9, 1, 64'h20,            64'h0,                 8'h00, 0, 64'h0000_0000_8765_4321, 1, 0);
    vecs[8]  = mk(64'h36,                64'h0,                 64'hBEEF_0000_0000_0000, 1, 0, 1, 0, 1, 10, 1, 64'h30,           64'h0,                 8'h00, 0, 64'hFFFF_FFFF_FFFF_BEEF, 1, 0);
    vecs[9]  = mk(64'h47,                64'h1122_3344_5566_77AB, 64'h0,               0, 1, 0, 0, 0, 0, 1, 64'h40,             64'hAB00_0000_0000_0000, 8'h80, 1, 64'h0,                0, 0);
    vecs[10] = mk(64'h48,                64'hCAFE_BABE_1234_5678, 64'h0,               0, 1, 3, 0, 0, 0, 1, 64'h48,             64'hCAFE_BABE_1234_5678, 8'hFF, 1, 64'h0,                0, 0);
    vecs[11] = mk(64'h52,                64'h1234,              64'h0,                 0, 1, 1, 0, 0, 0, 1, 64'h50,             64'h0000_0000_1234_0000, 8'h0C, 1, 64'h0,                0, 0);
    vecs[12] = mk(64'h60,                64'hFFFF,              64'h55,                1, 1, 3, 0, 1, 11, 1, 64'h60,            64'h0,                 8'h00, 0, 64'h55,                1, 0);
    vecs[13] = mk(64'h4,                 64'h77,                64'h0,                 0, 1, 3, 0, 0, 0, 0, 64'h0,              64'h0,                 8'h00, 0, 64'h0,                 0, 1);
    vecs[14] = mk(64'hABC,               64'h0,                 64'h0,                 0, 0, 0, 0, 1, 0, 0, 64'h0,              64'h0,                 8'h00, 0, 64'hABC,               1, 0);

    rst_n = 1'b1;
    ex_valid = 1'b0; ex_pc = '0; ex_alu_res = '0; ex_store_data = '0;
    ex_mem_ld = 1'b0; ex_mem_st = 1'b0; ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0;
    ex_reg_wen = 1'b0; ex_reg_waddr = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    wb_ready = 1'b1;

    #1;
    chk("rst ex_ready", 64'(ex_ready), 64'd1);
    chk("rst req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst req_wmask", 64'(dmem_req_wmask), 64'd0);
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    chk("rst wb_rdata", wb_rdata, 64'd0);
    chk("rst misalign", 64'(misalign_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;

    for (int i = 0; i < 15; i++) do_vec(i, vecs[i]);

    // ex_ready low for exactly one cycle around a pass-through op
    drive_ex(64'h2000, 64'h1234, 64'h0, 0, 0, 2'd3, 0, 1, 5'd5);
    @(negedge clk);
    chk("alu ready_low", 64'(ex_ready), 64'd0);
    chk("alu wb_valid", 64'(wb_valid), 64'd1);
    @(negedge clk);
    chk("alu ready_back", 64'(ex_ready), 64'd1);
    chk("alu wb_done", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;

    // store held off by dmem_req_ready, with stray responses along the way
    drive_ex(64'h2100, 64'h8000_0004, 64'hDEAD_BEEF, 0, 1, 2'd2, 0, 0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d req_valid", k), 64'(dmem_req_valid), 64'd1);
      chk($sformatf("stall%0d req_addr", k), dmem_req_addr, 64'h8000_0000);
      chk($sformatf("stall%0d req_wdata", k), dmem_req_wdata, 64'hDEAD_BEEF_0000_0000);
      chk($sformatf("stall%0d req_wmask", k), 64'(dmem_req_wmask), 64'hF0);
      chk($sformatf("stall%0d wb_valid", k), 64'(wb_valid), 64'd0);
      dmem_resp_valid = (k == 1);
    end
    @(negedge clk);
    chk("stall req_still", 64'(dmem_req_valid), 64'd1);
    dmem_req_ready = 1'b1;
    dmem_resp_valid = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stall same_cycle_resp_ignored", 64'(wb_valid), 64'd0);
    dmem_resp_valid = 1'b1;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stall wb_valid", 64'(wb_valid), 64'd1);
    chk("stall wb_reg_wen", 64'(wb_reg_wen), 64'd0);
    @(posedge clk); #1;

    // write-back backpressure on a completed ld
    wb_ready = 1'b0;
    drive_ex(64'h300, 64'h208, 64'h0, 1, 0, 2'd3, 0, 1, 5'd9);
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'h1122_3344_5566_7788;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 64'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d wb_valid", k), 64'(wb_valid), 64'd1);
      chk($sformatf("bp%0d wb_rdata", k), wb_rdata, 64'h1122_3344_5566_7788);
      chk($sformatf("bp%0d wb_reg_wen", k), 64'(wb_reg_wen), 64'd1);
      chk($sformatf("bp%0d wb_reg_waddr", k), 64'(wb_reg_waddr), 64'd9);
      chk($sformatf("bp%0d wb_pc", k), wb_pc, 64'h300);
      chk($sformatf("bp%0d ex_ready", k), 64'(ex_ready), 64'd0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake_cycle", 64'(wb_valid), 64'd1);
    @(negedge clk);
    chk("bp idle_ready", 64'(ex_ready), 64'd1);
    chk("bp idle_wb_valid", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;

    // misalign_err pulses only on the first OUT cycle
    wb_ready = 1'b0;
    drive_ex(64'h400, 64'h2, 64'h0, 1, 0, 2'd2, 0, 1, 5'd3);
    @(negedge clk);
    chk("mis first", 64'(misalign_err), 64'd1);
    chk("mis first_valid", 64'(wb_valid), 64'd1);
    chk("mis no_req", 64'(dmem_req_valid), 64'd0);
    @(negedge clk);
    chk("mis second", 64'(misalign_err), 64'd0);
    chk("mis second_valid", 64'(wb_valid), 64'd1);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset while waiting for the response
    drive_ex(64'h500, 64'h104, 64'h0, 1, 0, 2'd2, 0, 1, 5'd12);
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst wb_valid", 64'(wb_valid), 64'd0);
    chk("arst wb_pc", wb_pc, 64'd0);
    chk("arst waddr", 64'(wb_reg_waddr), 64'd0);
    chk("arst req_valid", 64'(dmem_req_valid), 64'd0);
    chk("arst ex_ready", 64'(ex_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("late_resp wb_valid", 64'(wb_valid), 64'd0);
    chk("late_resp ex_ready", 64'(ex_ready), 64'd1);
    @(posedge clk); #1;
    do_vec(20, vecs[6]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the execute stage and `wb_stage`.
- Accepts one instruction at a time from EX. Loads and stores go to the data memory over a valid/ready request and valid response bus. All other instructions pass straight through.
- Produces a registered result for write-back: `wb_rdata` drives `wb_stage`'s `from_mem_alu_res`, and `wb_reg_wen` and `wb_reg_waddr` feed its register-write inputs.
- Load data is fully aligned and extended here. Write-back receives final 64-bit register values.

Parameters:
- `XLEN`, 64, datapath and address width.
- `REG_ADDR_W`, 5, register address width. Must match `` `REG_ADDR_WIDTH ``.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (asserted = 1).
- `ex_valid`  in  1  EX presents an instruction.
- `ex_ready`  out  1  stage can accept an instruction this cycle.
- `ex_pc`  in  XLEN  instruction PC.
- `ex_alu_res`  in  XLEN  effective address (memory ops) or ALU result (other ops).
- `ex_store_data`  in  XLEN  rs2 value for stores.
- `ex_mem_ld`  in  1  instruction is a load.
- `ex_mem_st`  in  1  instruction is a store.
- `ex_mem_size`  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- `ex_mem_unsigned`  in  1  zero-extend the load (lbu/lhu/lwu).
- `ex_reg_wen`  in  1  instruction writes rd.
- `ex_reg_waddr`  in  REG_ADDR_W  rd.
- `dmem_req_valid`  out  1  memory request valid.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_req_addr`  out  XLEN  8-byte-aligned address (`addr[2:0]` = 0).
- `dmem_req_wen`  out  1  1 = write, 0 = read.
- `dmem_req_wdata`  out  XLEN  store data, lane-shifted.
- `dmem_req_wmask`  out  8  byte enables.
- `dmem_resp_valid`  in  1  response valid; one response per accepted request, for loads and stores alike.
- `dmem_resp_rdata`  in  XLEN  aligned 64-bit read data.
- `wb_valid`  out  1  result valid for write-back.
- `wb_ready`  in  1  write-back consumes the result.
- `wb_reg_wen`  out  1  write rd.
- `wb_reg_waddr`  out  REG_ADDR_W  rd.
- `wb_rdata`  out  XLEN  final register value.
- `wb_pc`  out  XLEN  PC of the instruction carried to write-back.
- `misalign_err`  out  1  one-cycle pulse coincident with `wb_valid` for a misaligned access.

Behaviour:
- Reset value of every output is 0, except `ex_ready`. The FSM resets to IDLE and `ex_ready` = 1 while reset is deasserted.
- Asserting reset mid-transaction aborts the transaction. An outstanding `dmem` response that arrives after reset is ignored.
- FSM states: IDLE, REQ, RESP, OUT.
- `ex_ready` = (state == IDLE).
- An instruction is accepted when `ex_valid && ex_ready`. All `ex_*` inputs are captured into internal registers at acceptance.
- Misalignment: an access is misaligned when `addr % (1 << size) != 0`.
- IDLE → OUT when the instruction is not a memory op, or it is misaligned:
  - Non-memory op: `wb_rdata` = `ex_alu_res`.
  - Misaligned access: `wb_reg_wen` = 0, `wb_rdata` = 0, `misalign_err` asserted for the first OUT cycle. No bus request is issued.
- IDLE → REQ for an aligned load or store:
  - `dmem_req_valid` = 1 with stable addr, wen, wdata and wmask until `dmem_req_ready` is sampled high.
  - Then REQ → RESP.
- RESP: wait for `dmem_resp_valid`, then RESP → OUT.
  - Load: `wb_rdata` = `rdata >> (8 * addr[2:0])`, truncated to the access size, then sign- or zero-extended per `ex_mem_unsigned`. Doubles are never extended.
  - Store: `wb_reg_wen` = 0.
- OUT: `wb_valid` = 1. Payload is held stable until `wb_ready`; then OUT → IDLE.
- Store formatting:
  - `wmask` = ((1 << (1 << size)) − 1) << `addr[2:0]`, truncated to 8 bits.
  - `wdata` = `store_data << (8 * addr[2:0])`.
- Latency from acceptance:
  - Non-memory op: `wb_valid` is 1 cycle after acceptance.
  - Memory op with zero-wait memory: 3 cycles (REQ, RESP, OUT).
  - Throughput is one instruction per 2 cycles at best. The next accept happens in the cycle after the OUT handshake.
- `dmem_resp_valid` outside RESP is ignored. This covers a stray response and one arriving in the same cycle as the request handshake.
- `ex_mem_ld` and `ex_mem_st` both high is illegal. The load takes priority.
- `ex_reg_wen` with rd = 0 is passed through unchanged. `wb_stage` drops x0 writes.

Decomposition:
- Shared package `mem_pkg`:
  - FSM state enum.
  - Size encodings `MEM_B/H/W/D`.
  - Function `size_bytes(size)`.
- One sub-module, `load_align`: combinational; inputs are rdata, `addr[2:0]`, size and unsigned; output is the extended 64-bit value.
- Mask and shift generation stay inline.

Test Plan:
- Non-memory op:
  - ALU op, `ex_alu_res` = 0x1234, rd = 5, `wb_ready` = 1.
  - Expect `wb_valid` next cycle with `wb_rdata` = 0x1234, `wb_reg_waddr` = 5, `wb_reg_wen` = 1.
  - `ex_ready` low exactly 1 cycle.
- Signed byte load:
  - lb, addr = 0x8000_0003, memory returns 0x0000_0000_8000_0000 in lane 3 (byte 0x80).
  - Expect `dmem_req_addr` = 0x8000_0000, `wmask` = 0, and `wb_rdata` = 0xFFFF_FFFF_FFFF_FF80.
  - Same access as lbu: expect 0x80.
- Word store:
  - sw, addr = 0x8000_0004, data = 0xDEAD_BEEF.
  - Expect `wmask` = 0xF0, `wdata` = 0xDEAD_BEEF_0000_0000.
  - `dmem_req_ready` held low 3 cycles: request stays stable across them.
  - After the response: `wb_valid` = 1, `wb_reg_wen` = 0.
- Misaligned access:
  - lh, addr = 0x8000_0001.
  - Expect no `dmem_req_valid`; next cycle `wb_valid` = 1, `misalign_err` = 1, `wb_reg_wen` = 0.
- Write-back backpressure:
  - ld completes while `wb_ready` = 0 for 4 cycles.
  - Expect `wb_*` stable throughout, `ex_ready` = 0, and an IDLE return one cycle after `wb_ready` rises.
- Reset mid-operation:
  - Assert `rst_n` (=1) in the RESP state.
  - Expect outputs 0 immediately (asynchronous).
  - After release: a late `dmem_resp_valid` is ignored, and the next instruction completes normally.
